vga_ctrl: RTL and testbench
===========================

Name: vga_ctrl

Overview:
- VGA timing generator and pixel sink for the 640x480@60 Hz display path (25.175/25.2 MHz vga_clk).
- Owns the horizontal/vertical counters and drives pix_x/pix_y to the pixel-generator screens (game, win, lose overlays). Those generators return 16-bit RGB565 pix_data combinationally.
- vga_ctrl registers that pix_data into rgb and produces hsync/vsync aligned with it for the DAC/connector.

Parameters:
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch
- H_VALID, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_VALID, 480, active lines
- V_FRONT, 10, vertical front porch
- Derived, not overridable:
  - H_TOTAL = 800
  - V_TOTAL = 525
  - H_ACT0 = H_SYNC+H_BACK = 144
  - V_ACT0 = V_SYNC+V_BACK = 35

Ports:
- vga_clk  input  1  pixel clock
- sys_rst_n  input  1  asynchronous active-low reset
- pix_data  input  16  RGB565 from pixel generator, combinational function of pix_x/pix_y
- pix_x  output  10  requested pixel column 0..639, 10'h3FF when not requesting
- pix_y  output  10  requested pixel row 0..479, 10'h3FF when not requesting
- hsync  output  1  horizontal sync, active-high
- vsync  output  1  vertical sync, active-high
- rgb  output  16  RGB565 to DAC, zero outside active area
- rgb_valid  output  1  high while rgb carries an active pixel
- frame_start  output  1  one-cycle pulse at start of each frame

Behaviour:
- Interface: one clock, vga_clk. Reset sys_rst_n is asynchronous and active-low. Every register clears immediately on sys_rst_n low, independent of vga_clk.
- Counters:
  - cnt_h is 10-bit, 0..H_TOTAL-1. It increments every cycle and wraps 799->0.
  - cnt_v is 10-bit, 0..V_TOTAL-1. It increments only when cnt_h==799 and wraps 524->0 at that same edge.
  - Reset value of both is 0.
- Sync (combinational from counters):
  - hsync = (cnt_h < H_SYNC)
  - vsync = (cnt_v < V_SYNC)
  - At and just after reset, hsync=1 and vsync=1.
- Pixel request, one cycle early to absorb rgb register latency:
  - pix_req = (cnt_h >= H_ACT0-1) && (cnt_h <= H_ACT0+H_VALID-2) && (cnt_v >= V_ACT0) && (cnt_v <= V_ACT0+V_VALID-1)
  - When pix_req: pix_x = cnt_h-(H_ACT0-1) and pix_y = cnt_v-V_ACT0.
  - Otherwise both are 10'h3FF. Reset value is 10'h3FF.
- Output register (latency 1):
  - rgb <= pix_req ? pix_data : 16'h0000
  - rgb_valid <= pix_req
  - Reset value of both is 0.
  - The pixel for (x,y) appears on rgb during cnt_h = 144+x, cnt_v = 35+y, in the same cycle as the matching sync levels.
  - rgb is never nonzero outside the 640x480 window, whatever pix_data holds.
- frame_start:
  - Registered. Goes high for exactly one cycle following the edge where cnt_h==799 && cnt_v==524, i.e. while counters read (0,0).
  - Reset value 0. No pulse is produced by reset itself; the first pulse comes after one full frame.
- Reset mid-frame: counters, rgb, rgb_valid and frame_start clear asynchronously. On release, counting restarts at (0,0) and the partial frame is discarded.
- Arithmetic: all compares are unsigned 10-bit. The subtractions for pix_x/pix_y are evaluated only inside the request window, so there is no underflow.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the eight timing constants and the derived H_TOTAL, V_TOTAL, H_ACT0, V_ACT0
  - the RGB565 colour constants (GREEN 16'h07E0, WHITE 16'hFFFF, YELLOW 16'hFFE0, BLACK 16'h0000) used by all screen generators
- No sub-module: counters, request decode and output register stay in one block. The screen mux above it selects which generator's pix_data feeds vga_ctrl.

Test Plan:
1. Reset:
   - Stimulus: hold sys_rst_n=0, then release.
   - Required while held: rgb=0, rgb_valid=0, frame_start=0, pix_x=pix_y=10'h3FF, hsync=1, vsync=1.
   - Required after release: first hsync falling edge 96 clocks after release.
2. Line/frame timing:
   - Stimulus: free-run.
   - Required: hsync period 800 clocks, high 96; vsync period 420000 clocks, high 1600; frame_start period 420000, width 1.
3. Pixel alignment:
   - Stimulus: pix_data = {pix_y[4:0], pix_x[5:0], pix_x[4:0]} echo model.
   - Required: at cnt_h=144, cnt_v=35, rgb holds the value for x=0,y=0 and rgb_valid=1. At cnt_h=783, rgb holds x=639. At cnt_h=784, rgb=0 and rgb_valid=0.
4. Blanking:
   - Stimulus: pix_data tied to 16'hFFFF.
   - Required: exactly 307200 cycles per frame with rgb=16'hFFFF and rgb_valid=1; rgb=0 in all other cycles; pix_x never exceeds 639 while pix_req.
5. Mid-frame reset:
   - Stimulus: assert sys_rst_n=0 at cnt_v=200, cnt_h=400 for 3 clocks without a clock edge aligned to the assertion.
   - Required: outputs clear immediately; after release, timing restarts from (0,0); the next frame_start comes 420000 clocks after release.
6. Wrap:
   - Stimulus: observe cnt_h=799, cnt_v=524.
   - Required: next cycle cnt_h=0, cnt_v=0, frame_start=1, vsync=1, hsync=1; following cycle frame_start=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and RGB565 colours shared by the display path
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_VALID = 640;
    localparam int H_FRONT = 16;

    // Vertical timing, in lines
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_VALID = 480;
    localparam int V_FRONT = 10;

    // Derived frame geometry
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_ACT0  = H_SYNC + H_BACK;
    localparam int V_ACT0  = V_SYNC + V_BACK;

    // RGB565 colours used by the screen generators
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] BLACK  = 16'h0000;

endpackage

// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA timing generator with registered RGB565 pixel sink
module vga_ctrl #(
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BACK  = vga_timing_pkg::H_BACK,
    parameter int H_VALID = vga_timing_pkg::H_VALID,
    parameter int H_FRONT = vga_timing_pkg::H_FRONT,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BACK  = vga_timing_pkg::V_BACK,
    parameter int V_VALID = vga_timing_pkg::V_VALID,
    parameter int V_FRONT = vga_timing_pkg::V_FRONT
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        rgb_valid,
    output logic        frame_start
);

    // Last counter values before wrap
    localparam logic [9:0] H_LAST = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [9:0] V_LAST = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);

    // Request window is shifted one clock earlier than the visible window so the
    // registered rgb lines up with the sync levels of the pixel it belongs to
    localparam logic [9:0] REQ_H0 = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] REQ_H1 = 10'(H_SYNC + H_BACK + H_VALID - 2);
    localparam logic [9:0] REQ_V0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] REQ_V1 = 10'(V_SYNC + V_BACK + V_VALID - 1);
    localparam logic [9:0] HS_END = 10'(H_SYNC);
    localparam logic [9:0] VS_END = 10'(V_SYNC);

    logic [9:0]  cnt_h_q, cnt_h_d;
    logic [9:0]  cnt_v_q, cnt_v_d;
    logic [15:0] rgb_q, rgb_d;
    logic        rgb_valid_q, rgb_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        h_wrap;
    logic        pix_req;

    // Counter advance, pixel request decode and output-register next state
    always_comb begin
        h_wrap        = (cnt_h_q == H_LAST);
        cnt_h_d       = h_wrap ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d       = cnt_v_q;
        if (h_wrap) begin
            cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
        end
        frame_start_d = h_wrap && (cnt_v_q == V_LAST);

        pix_req = (cnt_h_q >= REQ_H0) && (cnt_h_q <= REQ_H1) &&
                  (cnt_v_q >= REQ_V0) && (cnt_v_q <= REQ_V1);
        pix_x   = 10'h3FF;
        pix_y   = 10'h3FF;
        if (pix_req) begin
            pix_x = cnt_h_q - REQ_H0;
            pix_y = cnt_v_q - REQ_V0;
        end

        // Blank rgb outside the window regardless of what the generator drives
        rgb_d       = pix_req ? pix_data : 16'h0000;
        rgb_valid_d = pix_req;
    end

    // State registers, cleared asynchronously so a mid-frame reset discards the frame
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q       <= 10'd0;
            cnt_v_q       <= 10'd0;
            rgb_q         <= 16'h0000;
            rgb_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            rgb_q         <= rgb_d;
            rgb_valid_q   <= rgb_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = (cnt_h_q < HS_END);
    assign vsync       = (cnt_v_q < VS_END);
    assign rgb         = rgb_q;
    assign rgb_valid   = rgb_valid_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - self-checking bench for vga_ctrl (full-size and shrunk timing instances)
module tb_vga_ctrl;
    import vga_timing_pkg::*;

    typedef struct {
        int hs; int hb; int hv; int hf;
        int vs; int vb; int vv; int vf;
    } tcfg_t;

    typedef struct {
        int          n;
        logic        hs;
        logic        vs;
        logic        vld;
        logic [15:0] rgb;
        logic [9:0]  px;
        logic [9:0]  py;
    } vec_t;

    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic        rst_a_n, rst_b_n;
    logic [15:0] data_a, data_b, rgb_a, rgb_b;
    logic [9:0]  px_a, py_a, px_b, py_b;
    logic        hs_a, vs_a, vld_a, fs_a;
    logic        hs_b, vs_b, vld_b, fs_b;

    // Echo generator on the full-size instance, solid white on the shrunk one
    assign data_a = {py_a[4:0], px_a[5:0], px_a[4:0]};
    assign data_b = WHITE;

    vga_ctrl u_dut_a (
        .vga_clk(vga_clk), .sys_rst_n(rst_a_n), .pix_data(data_a),
        .pix_x(px_a), .pix_y(py_a), .hsync(hs_a), .vsync(vs_a),
        .rgb(rgb_a), .rgb_valid(vld_a), .frame_start(fs_a)
    );

    vga_ctrl #(
        .H_SYNC(3), .H_BACK(2), .H_VALID(6), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_VALID(3), .V_FRONT(2)
    ) u_dut_b (
        .vga_clk(vga_clk), .sys_rst_n(rst_b_n), .pix_data(data_b),
        .pix_x(px_b), .pix_y(py_b), .hsync(hs_b), .vsync(vs_b),
        .rgb(rgb_b), .rgb_valid(vld_b), .frame_start(fs_b)
    );

    localparam int FT_B = 13 * 8;

    int errors = 0;
    int checks = 0;
    int na, nb;
    tcfg_t cfg_a, cfg_b;
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    vec_t tbl[$];

    task automatic chk(input string name, input int n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    // Reference timing derived from the cycle count since reset release
    task automatic model(input tcfg_t c, input int n, output logic ehs, output logic evs,
                         output logic ereq, output logic efs, output logic [9:0] ex, output logic [9:0] ey);
        int ht, vt, h, v, ha, va;
        ht   = c.hs + c.hb + c.hv + c.hf;
        vt   = c.vs + c.vb + c.vv + c.vf;
        h    = n % ht;
        v    = (n / ht) % vt;
        ha   = c.hs + c.hb;
        va   = c.vs + c.vb;
        ehs  = (h < c.hs);
        evs  = (v < c.vs);
        ereq = (h >= ha - 1) && (h <= ha + c.hv - 2) && (v >= va) && (v <= va + c.vv - 1);
        ex   = ereq ? 10'(h - (ha - 1)) : 10'h3FF;
        ey   = ereq ? 10'(v - va) : 10'h3FF;
        efs  = (n > 0) && (n % (ht * vt) == 0);
    endtask

    task automatic sample_a();
        logic ehs, evs, ereq, efs;
        logic [9:0] ex, ey;
        logic [16:0] e;
        model(cfg_a, na, ehs, evs, ereq, efs, ex, ey);
        if (qa.size() == 0) begin
            chk("a_queue_empty", na, 16'(qa.size()), 16'd1);
        end else begin
            e = qa.pop_front();
            chk("a_rgb_valid", na, 16'(vld_a), 16'(e[16]));
            chk("a_rgb", na, rgb_a, e[15:0]);
        end
        chk("a_hsync", na, 16'(hs_a), 16'(ehs));
        chk("a_vsync", na, 16'(vs_a), 16'(evs));
        chk("a_frame_start", na, 16'(fs_a), 16'(efs));
        chk("a_pix_x", na, 16'(px_a), 16'(ex));
        chk("a_pix_y", na, 16'(py_a), 16'(ey));
        qa.push_back({ereq, ereq ? {ey[4:0], ex[5:0], ex[4:0]} : 16'h0000});
    endtask

    task automatic sample_b();
        logic ehs, evs, ereq, efs;
        logic [9:0] ex, ey;
        logic [16:0] e;
        model(cfg_b, nb, ehs, evs, ereq, efs, ex, ey);
        if (qb.size() == 0) begin
            chk("b_queue_empty", nb, 16'(qb.size()), 16'd1);
        end else begin
            e = qb.pop_front();
            chk("b_rgb_valid", nb, 16'(vld_b), 16'(e[16]));
            chk("b_rgb", nb, rgb_b, e[15:0]);
        end
        chk("b_hsync", nb, 16'(hs_b), 16'(ehs));
        chk("b_vsync", nb, 16'(vs_b), 16'(evs));
        chk("b_frame_start", nb, 16'(fs_b), 16'(efs));
        chk("b_pix_x", nb, 16'(px_b), 16'(ex));
        chk("b_pix_y", nb, 16'(py_b), 16'(ey));
        qb.push_back({ereq, ereq ? WHITE : 16'h0000});
    endtask

    task automatic step_a();
        @(negedge vga_clk);
        na++;
        sample_a();
    endtask

    task automatic step_b();
        @(negedge vga_clk);
        nb++;
        sample_b();
    endtask

    task automatic chk_reset_b(input string tag);
        chk({tag, "_rgb"}, nb, rgb_b, 16'h0000);
        chk({tag, "_rgb_valid"}, nb, 16'(vld_b), 16'd0);
        chk({tag, "_frame_start"}, nb, 16'(fs_b), 16'd0);
        chk({tag, "_pix_x"}, nb, 16'(px_b), 16'h03FF);
        chk({tag, "_pix_y"}, nb, 16'(py_b), 16'h03FF);
        chk({tag, "_hsync"}, nb, 16'(hs_b), 16'd1);
        chk({tag, "_vsync"}, nb, 16'(vs_b), 16'd1);
    endtask

    initial begin
        int act_cnt, white_cnt, hs_cnt, vs_cnt, fs_cnt, max_px;
        cfg_a = '{H_SYNC, H_BACK, H_VALID, H_FRONT, V_SYNC, V_BACK, V_VALID, V_FRONT};
        cfg_b = '{3, 2, 6, 2, 2, 1, 3, 2};

        // Hand-derived points on the full-size raster (n = clocks since release)
        tbl.push_back('{0,     1'b1, 1'b1, 1'b0, 16'h0000, 10'h3FF, 10'h3FF});
        tbl.push_back('{95,    1'b1, 1'b1, 1'b0, 16'h0000, 10'h3FF, 10'h3FF});
        tbl.push_back('{96,    1'b0, 1'b1, 1'b0, 16'h0000, 10'h3FF, 10'h3FF});
        tbl.push_back('{800,   1'b1, 1'b1, 1'b0, 16'h0000, 10'h3FF, 10'h3FF});
        tbl.push_back('{1600,  1'b1, 1'b0, 1'b0, 16'h0000, 10'h3FF, 10'h3FF});
        tbl.push_back('{28143, 1'b0, 1'b0, 1'b0, 16'h0000, 10'd0,   10'd0});
        tbl.push_back('{28144, 1'b0, 1'b0, 1'b1, 16'h0000, 10'd1,   10'd0});
        tbl.push_back('{28145, 1'b0, 1'b0, 1'b1, 16'h0021, 10'd2,   10'd0});
        tbl.push_back('{28782, 1'b0, 1'b0, 1'b1, 16'h07DE, 10'd639, 10'd0});
        tbl.push_back('{28783, 1'b0, 1'b0, 1'b1, 16'h07FF, 10'h3FF, 10'h3FF});
        tbl.push_back('{28784, 1'b0, 1'b0, 1'b0, 16'h0000, 10'h3FF, 10'h3FF});
        tbl.push_back('{28943, 1'b0, 1'b0, 1'b0, 16'h0000, 10'd0,   10'd1});
        tbl.push_back('{28944, 1'b0, 1'b0, 1'b1, 16'h0800, 10'd1,   10'd1});

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        na = 0;
        nb = 0;
        #23;
        chk("rst_a_rgb", 0, rgb_a, 16'h0000);
        chk("rst_a_rgb_valid", 0, 16'(vld_a), 16'd0);
        chk("rst_a_frame_start", 0, 16'(fs_a), 16'd0);
        chk("rst_a_pix_x", 0, 16'(px_a), 16'h03FF);
        chk("rst_a_pix_y", 0, 16'(py_a), 16'h03FF);
        chk("rst_a_hsync", 0, 16'(hs_a), 16'd1);
        chk("rst_a_vsync", 0, 16'(vs_a), 16'd1);

        // Full-size instance: release, then walk the table with the scoreboard running
        @(negedge vga_clk);
        rst_a_n = 1'b1;
        #1;
        qa.delete();
        qa.push_back(17'h0);
        sample_a();
        foreach (tbl[i]) begin
            while (na < tbl[i].n) step_a();
            chk("tbl_hsync", na, 16'(hs_a), 16'(tbl[i].hs));
            chk("tbl_vsync", na, 16'(vs_a), 16'(tbl[i].vs));
            chk("tbl_rgb_valid", na, 16'(vld_a), 16'(tbl[i].vld));
            chk("tbl_rgb", na, rgb_a, tbl[i].rgb);
            chk("tbl_pix_x", na, 16'(px_a), 16'(tbl[i].px));
            chk("tbl_pix_y", na, 16'(py_a), 16'(tbl[i].py));
        end

        // Shrunk instance still held in reset the whole time
        chk_reset_b("held_b");

        // Shrunk instance: two full frames with aggregate counts
        @(negedge vga_clk);
        rst_b_n = 1'b1;
        #1;
        qb.delete();
        qb.push_back(17'h0);
        act_cnt = 0; white_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; max_px = 0;
        sample_b();
        while (nb < 2 * FT_B + 45) begin
            if (nb < FT_B) begin
                if (vld_b) act_cnt++;
                if (rgb_b == WHITE) white_cnt++;
                if (vs_b) vs_cnt++;
            end
            if (nb < 13 && hs_b) hs_cnt++;
            if (fs_b) fs_cnt++;
            if (px_b != 10'h3FF && int'(px_b) > max_px) max_px = int'(px_b);
            step_b();
        end
        chk("b_active_per_frame", nb, 16'(act_cnt), 16'd18);
        chk("b_white_per_frame", nb, 16'(white_cnt), 16'd18);
        chk("b_hsync_high", nb, 16'(hs_cnt), 16'd3);
        chk("b_vsync_high", nb, 16'(vs_cnt), 16'd26);
        chk("b_frame_pulses", nb, 16'(fs_cnt), 16'd2);
        chk("b_max_pix_x", nb, 16'(max_px), 16'd5);
        chk("b_pre_reset_valid", nb, 16'(vld_b), 16'd1);

        // Mid-frame reset, asserted away from any clock edge
        #2;
        rst_b_n = 1'b0;
        #1;
        chk_reset_b("midrst_b");
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        chk_reset_b("midrst_hold_b");
        rst_b_n = 1'b1;
        #1;
        nb = 0;
        qb.delete();
        qb.push_back(17'h0);
        sample_b();
        while (nb < FT_B - 1) step_b();
        chk("wrap_pre_fs", nb, 16'(fs_b), 16'd0);
        chk("wrap_pre_hsync", nb, 16'(hs_b), 16'd0);
        chk("wrap_pre_vsync", nb, 16'(vs_b), 16'd0);
        step_b();
        chk("wrap_fs", nb, 16'(fs_b), 16'd1);
        chk("wrap_hsync", nb, 16'(hs_b), 16'd1);
        chk("wrap_vsync", nb, 16'(vs_b), 16'd1);
        step_b();
        chk("wrap_post_fs", nb, 16'(fs_b), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
